// File: rtl/ibex_dummy_instr_checker_if.sv
// ---------------------------------------------------------------------------
// ibex_dummy_instr_checker_if
//
// Purpose: groups the observation bus of the dummy-instruction checker. It
// carries the inserter configuration (enable and mask), the ID-stage
// handshake with its instruction word, the clear request and the checker's
// status outputs.
//
// Signals:
//   dummy_instr_en_i    dummy insertion enabled
//   dummy_instr_mask_i  insertion frequency mask (3 bits)
//   instr_valid_i       instruction presented to ID
//   id_in_ready_i       ID accepts the instruction
//   instr_is_dummy_i    presented instruction is an inserted dummy
//   instr_rdata_i       presented instruction word (32 bits)
//   clear_i             clears the alerts and the counters
//   dummy_count_o       number of accepted dummy instructions
//   alert_encoding_o    sticky malformed-dummy alert
//   alert_timeout_o     sticky missing-dummy alert
//   state_o             checker state: 00 DISABLED, 01 MONITOR, 10 ALERT
//
// Modports: master drives the inputs and observes the status (the
// environment); slave is the checker itself.
// ---------------------------------------------------------------------------
interface ibex_dummy_instr_checker_if #(
    parameter int DummyCntW = 16
);
    logic                 dummy_instr_en_i;
    logic [2:0]           dummy_instr_mask_i;
    logic                 instr_valid_i;
    logic                 id_in_ready_i;
    logic                 instr_is_dummy_i;
    logic [31:0]          instr_rdata_i;
    logic                 clear_i;
    logic [DummyCntW-1:0] dummy_count_o;
    logic                 alert_encoding_o;
    logic                 alert_timeout_o;
    logic [1:0]           state_o;

    modport master (
        output dummy_instr_en_i, dummy_instr_mask_i, instr_valid_i,
               id_in_ready_i, instr_is_dummy_i, instr_rdata_i, clear_i,
        input  dummy_count_o, alert_encoding_o, alert_timeout_o, state_o
    );

    modport slave (
        input  dummy_instr_en_i, dummy_instr_mask_i, instr_valid_i,
               id_in_ready_i, instr_is_dummy_i, instr_rdata_i, clear_i,
        output dummy_count_o, alert_encoding_o, alert_timeout_o, state_o
    );
endinterface

// File: rtl/ibex_dummy_instr_checker.sv
// ---------------------------------------------------------------------------
// ibex_dummy_instr_checker
//
// Purpose: watches the instructions accepted by the ID stage and checks the
// dummy-instruction inserter. A dummy must be a harmless R-type OP with rd=x0
// (ADD, MUL, DIV or AND; rs1/rs2 free). No dummy may be seen at all while
// insertion is disabled. Optionally, too many real instructions in a row
// without a dummy raise a timeout alert. Both alerts are sticky and move the
// checker into ALERT until clear_i.
//
// Ports:
//   clk_i   single clock, rising edge
//   rst_i   synchronous active-high reset (wins over clear_i and accepts)
//   bus     ibex_dummy_instr_checker_if.slave (see the interface file)
//
// Configuration macro: IBEX_DUMMY_CHECK_TIMEOUT_EN
//   defined   : a 6-bit gap counter and the timeout alert are built
//   undefined : no gap counter, alert_timeout_o is tied to 0
//
// All outputs come straight from flops (one-cycle latency from the inputs).
// ---------------------------------------------------------------------------
module ibex_dummy_instr_checker #(
    parameter int DummyCntW = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    ibex_dummy_instr_checker_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_DISABLED = 2'b00,
        ST_MONITOR  = 2'b01,
        ST_ALERT    = 2'b10
    } state_e;

    localparam logic [DummyCntW-1:0] CntMax = '1;

    // Legal dummy: rd=x0, opcode OP, and {funct7,funct3} selects ADD, MUL,
    // DIV or AND.
    function automatic logic is_legal_dummy(input logic [31:0] w);
        logic [9:0] k;
        k = {w[31:25], w[14:12]};
        is_legal_dummy = 1'b0;
        if (w[11:0] == 12'h033) begin
            case (k)
                10'b0000000_000,
                10'b0000001_000,
                10'b0000001_100,
                10'b0000000_111: is_legal_dummy = 1'b1;
                default:         is_legal_dummy = 1'b0;
            endcase
        end
    endfunction

    function automatic logic [DummyCntW-1:0] sat_inc_cnt(input logic [DummyCntW-1:0] v);
        sat_inc_cnt = (v == CntMax) ? v : v + DummyCntW'(1);
    endfunction

    state_e               r_state;
    state_e               w_state_next;
    logic [DummyCntW-1:0] r_count;
    logic                 r_alert_enc;
    logic                 r_alert_to;

    logic w_accept;
    logic w_acc_dummy;
    logic w_acc_real;
    logic w_set_enc;
    logic w_set_to;
    logic w_enter_monitor;

    assign w_accept    = bus.instr_valid_i & bus.id_in_ready_i;
    assign w_acc_dummy = w_accept & bus.instr_is_dummy_i;
    assign w_acc_real  = w_accept & ~bus.instr_is_dummy_i;

    // Judged against the current state, so an accept that coincides with
    // leaving MONITOR is still checked with MONITOR rules. ALERT raises
    // nothing new; its alerts are already latched.
    always_comb begin
        w_set_enc = 1'b0;
        if (w_acc_dummy) begin
            case (r_state)
                ST_MONITOR:  w_set_enc = ~is_legal_dummy(bus.instr_rdata_i);
                ST_DISABLED: w_set_enc = 1'b1;
                default:     w_set_enc = 1'b0;
            endcase
        end
    end

    assign w_enter_monitor = (r_state == ST_DISABLED) && (w_state_next == ST_MONITOR);

`ifdef IBEX_DUMMY_CHECK_TIMEOUT_EN
    logic [5:0] r_gap;
    logic [5:0] w_gap_inc;

    assign w_gap_inc = (r_gap == 6'd63) ? r_gap : r_gap + 6'd1;

    // Limit is {mask,2'b11}: 3, 7, ... 31 real instructions between dummies.
    assign w_set_to = (r_state == ST_MONITOR) && w_acc_real &&
                      (w_gap_inc > {1'b0, bus.dummy_instr_mask_i, 2'b11});

    always_ff @(posedge clk_i) begin
        if (rst_i || bus.clear_i) begin
            r_gap <= 6'd0;
        end else if (w_enter_monitor || w_acc_dummy) begin
            r_gap <= 6'd0;
        end else if (w_acc_real) begin
            r_gap <= w_gap_inc;
        end
    end

    logic w_unused;
    assign w_unused = ^bus.instr_rdata_i[24:15];
`else
    assign w_set_to = 1'b0;

    logic w_unused;
    assign w_unused = ^{bus.instr_rdata_i[24:15], bus.dummy_instr_mask_i};
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_DISABLED;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        if (bus.clear_i) begin
            w_state_next = ST_DISABLED;
        end else begin
            case (r_state)
                ST_DISABLED: begin
                    if (w_set_enc || w_set_to)    w_state_next = ST_ALERT;
                    else if (bus.dummy_instr_en_i) w_state_next = ST_MONITOR;
                end
                ST_MONITOR: begin
                    if (w_set_enc || w_set_to)     w_state_next = ST_ALERT;
                    else if (!bus.dummy_instr_en_i) w_state_next = ST_DISABLED;
                end
                ST_ALERT:    w_state_next = ST_ALERT;
                default:     w_state_next = ST_DISABLED;
            endcase
        end
    end

    // Counter and sticky alerts
    always_ff @(posedge clk_i) begin
        if (rst_i || bus.clear_i) begin
            r_count     <= '0;
            r_alert_enc <= 1'b0;
            r_alert_to  <= 1'b0;
        end else begin
            if (w_acc_dummy) begin
                r_count <= sat_inc_cnt(r_count);
            end
            r_alert_enc <= r_alert_enc | w_set_enc;
            r_alert_to  <= r_alert_to  | w_set_to;
        end
    end

    // Output logic
    always_comb begin
        bus.state_o          = r_state;
        bus.dummy_count_o    = r_count;
        bus.alert_encoding_o = r_alert_enc;
        bus.alert_timeout_o  = r_alert_to;
    end

endmodule

// File: tb/tb_ibex_dummy_instr_checker.sv
module tb_ibex_dummy_instr_checker;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
`ifdef IBEX_DUMMY_CHECK_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int S_DIS = 0, S_MON = 1, S_ALT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ibex_dummy_instr_checker_if #(.DummyCntW(CW)) bus();
  ibex_dummy_instr_checker #(.DummyCntW(CW)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    int    cnt;
    bit    enc;
    bit    to;
    int    st;
    string tag;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_state = S_DIS, m_cnt = 0, m_gap = 0;
  bit m_enc = 0, m_to = 0;
  string cur_tag = "reset";

  logic [9:0] allowed [0:3] = '{10'b0000000_000, 10'b0000001_000,
                                10'b0000001_100, 10'b0000000_111};

  function automatic bit ref_legal(logic [31:0] w);
    if (w[11:0] != 12'h033) return 1'b0;
    for (int i = 0; i < 4; i++)
      if ({w[31:25], w[14:12]} == allowed[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [9:0]  k;
    logic [31:0] w;
    int sel;
    k = allowed[$urandom % 4];
    w = {k[9:3], 5'($urandom), 5'($urandom), k[2:0], 5'd0, 7'h33};
    sel = $urandom % 4;
    if (sel == 0) w = $urandom;
    else if (sel == 1) w = w ^ (32'd1 << ($urandom % 32));
    return w;
  endfunction

  // Behavioural model: outcome of one clock edge given this cycle's inputs.
  task automatic model_step(bit en, int mask, bit acc, bit dummy, logic [31:0] word,
                            bit clr, bit r);
    exp_t e;
    bit set_enc, set_to;
    int ngap;
    if (r || clr) begin
      m_state = S_DIS; m_cnt = 0; m_gap = 0; m_enc = 0; m_to = 0;
    end else begin
      set_enc = 0; set_to = 0; ngap = m_gap;
      if (acc && dummy) begin
        if (m_state == S_MON) set_enc = !ref_legal(word);
        else if (m_state == S_DIS) set_enc = 1;
        if (m_cnt < CMAX) m_cnt++;
        ngap = 0;
      end else if (acc) begin
        ngap = (m_gap < 63) ? m_gap + 1 : 63;
        if (TO_EN && m_state == S_MON && ngap > mask * 4 + 3) set_to = 1;
      end
      if (m_state == S_ALT) begin
        m_state = S_ALT;
      end else if (set_enc || set_to) begin
        m_state = S_ALT;
      end else if (m_state == S_DIS && en) begin
        m_state = S_MON;
        ngap = 0;
      end else if (m_state == S_MON && !en) begin
        m_state = S_DIS;
      end
      m_gap = ngap;
      m_enc = m_enc | set_enc;
      m_to  = m_to | set_to;
    end
    e.cnt = m_cnt; e.enc = m_enc; e.to = m_to; e.st = m_state; e.tag = cur_tag;
    q.push_back(e);
  endtask

  task automatic cyc(bit en, logic [2:0] mask, bit valid, bit ready, bit dummy,
                     logic [31:0] word, bit clr, bit r);
    @(negedge clk);
    bus.dummy_instr_en_i   = en;
    bus.dummy_instr_mask_i = mask;
    bus.instr_valid_i      = valid;
    bus.id_in_ready_i      = ready;
    bus.instr_is_dummy_i   = dummy;
    bus.instr_rdata_i      = word;
    bus.clear_i            = clr;
    rst                    = r;
    model_step(en, int'(mask), valid && ready, dummy, word, clr, r);
  endtask

  task automatic idle(bit en, logic [2:0] mask);
    cyc(en, mask, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask
  task automatic real_acc(bit en, logic [2:0] mask);
    cyc(en, mask, 1'b1, 1'b1, 1'b0, 32'h00A00513, 1'b0, 1'b0);
  endtask
  task automatic dummy_acc(bit en, logic [2:0] mask, logic [31:0] w);
    cyc(en, mask, 1'b1, 1'b1, 1'b1, w, 1'b0, 1'b0);
  endtask
  task automatic do_clear();
    cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  // Direct check against spec constants, just after the edge that follows
  // the last driven cycle.
  task automatic chk_now(string name, int cnt, bit enc, bit to, int st);
    @(posedge clk); #3;
    checks++;
    if (bus.dummy_count_o !== CW'(cnt) || bus.alert_encoding_o !== enc ||
        bus.alert_timeout_o !== to || bus.state_o !== 2'(st)) begin
      errors++;
      $display("FAIL %s: got cnt=%0d enc=%0b to=%0b st=%0d, want cnt=%0d enc=%0b to=%0b st=%0d",
               name, bus.dummy_count_o, bus.alert_encoding_o, bus.alert_timeout_o,
               bus.state_o, cnt, enc, to, st);
    end
  endtask

  // Scoreboard monitor: outputs are presented every cycle after each edge.
  always begin
    exp_t e;
    @(posedge clk); #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (bus.dummy_count_o !== CW'(e.cnt) || bus.alert_encoding_o !== e.enc ||
          bus.alert_timeout_o !== e.to || bus.state_o !== 2'(e.st)) begin
        errors++;
        $display("FAIL sb[%s] t=%0t: got cnt=%0d enc=%0b to=%0b st=%0d, want cnt=%0d enc=%0b to=%0b st=%0d",
                 e.tag, $time, bus.dummy_count_o, bus.alert_encoding_o, bus.alert_timeout_o,
                 bus.state_o, e.cnt, e.enc, e.to, e.st);
      end
    end
  end

  initial begin
    bus.dummy_instr_en_i = 0; bus.dummy_instr_mask_i = 0; bus.instr_valid_i = 0;
    bus.id_in_ready_i = 0; bus.instr_is_dummy_i = 0; bus.instr_rdata_i = 0;
    bus.clear_i = 0;

    cur_tag = "reset";
    cyc(1'b1, 3'd0, 1'b1, 1'b1, 1'b1, 32'h000000B3, 1'b1, 1'b1);
    cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk_now("reset", 0, 0, 0, S_DIS);

    cur_tag = "legal_dummy";
    idle(1'b1, 3'd0);
    repeat (3) real_acc(1'b1, 3'd0);
    dummy_acc(1'b1, 3'd0, 32'h00000033);
    chk_now("legal_dummy", 1, 0, 0, S_MON);

    cur_tag = "bad_rd";
    dummy_acc(1'b1, 3'd0, 32'h000000B3);
    chk_now("bad_rd", 2, 1, 0, S_ALT);
    do_clear();
    chk_now("clear1", 0, 0, 0, S_DIS);

    cur_tag = "timeout7";
    idle(1'b1, 3'd1);
    repeat (7) real_acc(1'b1, 3'd1);
    chk_now("gap7_no_alert", 0, 0, 0, S_MON);
    dummy_acc(1'b1, 3'd1, 32'h02000033);
    cur_tag = "timeout8";
    repeat (8) real_acc(1'b1, 3'd1);
    chk_now("gap8_alert", 1, 0, TO_EN, TO_EN ? S_ALT : S_MON);
    do_clear();

    cur_tag = "disabled_dummy";
    idle(1'b0, 3'd0);
    dummy_acc(1'b0, 3'd0, 32'h02004033);
    chk_now("disabled_dummy", 1, 1, 0, S_ALT);
    cur_tag = "clear_with_accept";
    cyc(1'b1, 3'd0, 1'b1, 1'b1, 1'b1, 32'h000000B3, 1'b1, 1'b0);
    chk_now("clear_with_accept", 0, 0, 0, S_DIS);

    cur_tag = "saturate";
    idle(1'b1, 3'd7);
    for (int i = 0; i < (1 << CW) + 2; i++) dummy_acc(1'b1, 3'd7, 32'h0000F033);
    chk_now("saturate", CMAX, 0, 0, S_MON);
    cur_tag = "midrun_reset";
    cyc(1'b1, 3'd7, 1'b1, 1'b1, 1'b1, 32'h000000B3, 1'b0, 1'b1);
    chk_now("midrun_reset", 0, 0, 0, S_DIS);

    cur_tag = "random";
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom % 8) != 0, 3'($urandom), ($urandom % 4) != 0, ($urandom % 4) != 0,
          ($urandom % 6) == 0, rand_word(), ($urandom % 40) == 0, ($urandom % 300) == 0);
    end

    idle(1'b0, 3'd0);
    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
